// File: rtl/capture_reader_if.sv
// Bundles the FIFO read port, host stream and status signals of capture_reader.
interface capture_reader_if #(
  parameter int unsigned DATA_SIZE = 4,
  parameter int unsigned ADDR_SIZE = 2
);
  logic                 enable_i;
  logic                 fifo_full_i;
  logic [ADDR_SIZE-1:0] r_addr_o;
  logic [DATA_SIZE-1:0] r_data_i;
  logic [DATA_SIZE-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 last_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 rearm_o;

  modport master (
    input  enable_i, fifo_full_i, r_data_i, ready_i,
    output r_addr_o, data_o, valid_o, last_o, busy_o, done_o, rearm_o
  );

  modport slave (
    output enable_i, fifo_full_i, r_data_i, ready_i,
    input  r_addr_o, data_o, valid_o, last_o, busy_o, done_o, rearm_o
  );
endinterface

// File: rtl/capture_reader.sv
// Read-side controller for the trigger capture FIFO: waits for full, streams
// every location in address order, then requests a re-arm of the write side.
module capture_reader #(
  parameter int unsigned DATA_SIZE = 4,
  parameter int unsigned ADDR_SIZE = 2
) (
  input  logic              clk_i,
  input  logic              rst,
  capture_reader_if.master  bus
);
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    PRESENT,
    DONE
  } state_t;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] r_addr_q, r_addr_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic                 rearm_q, rearm_d;
  logic                 sync1_q, sync2_q;
  logic                 full_s;

  assign full_s = sync2_q;

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.fifo_full_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      r_addr_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      rearm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_addr_q <= r_addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      rearm_q  <= rearm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    r_addr_d = r_addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    rearm_d  = rearm_q;

    unique case (state_q)
      IDLE: begin
        r_addr_d = '0;
        if (full_s && bus.enable_i) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        data_d  = bus.r_data_i;
        valid_d = 1'b1;
        last_d  = (r_addr_q == LAST_ADDR);
        state_d = PRESENT;
      end
      PRESENT: begin
        if (valid_q && bus.ready_i) begin
          valid_d = 1'b0;
          if (last_q) begin
            // Finish on the last address instead of wrapping back to 0.
            last_d  = 1'b0;
            done_d  = 1'b1;
            rearm_d = 1'b1;
            state_d = DONE;
          end else begin
            r_addr_d = r_addr_q + 1'b1;
            state_d  = FETCH;
          end
        end
      end
      DONE: begin
        // Stay here while the write side still reports full, so a stale flag never starts a frame.
        if (!full_s) begin
          rearm_d  = 1'b0;
          r_addr_d = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.r_addr_o = r_addr_q;
  assign bus.data_o   = data_q;
  assign bus.valid_o  = valid_q;
  assign bus.last_o   = last_q;
  assign bus.busy_o   = (state_q != IDLE);
  assign bus.done_o   = done_q;
  assign bus.rearm_o  = rearm_q;
endmodule
